// File: rtl/reg_file_pkg.sv
// Shared helpers for the register file: address sizing and the byte-strobe merge
// used by both the storage update and the write-to-read bypass.
package reg_file_pkg;

    localparam int unsigned MAX_W = 1024;
    localparam int unsigned MAX_S = MAX_W / 8;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Callers zero-extend to MAX_W and truncate the result back to their width.
    function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old_w,
                                               input logic [MAX_W-1:0] new_w,
                                               input logic [MAX_S-1:0] strb);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_S); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_word.sv
// One register-file entry with byte-strobed write and synchronous clear.
module reg_word
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SW   = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [SW-1:0]    strb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = WIDTH'(merge(MAX_W'(q_q), MAX_W'(d), MAX_S'(strb)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_file.sv
// Multi-entry register file: one byte-strobed write port, two combinational read
// ports, optional hardwired-zero entry 0 and optional same-cycle write bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = addr_w(DEPTH),
    localparam int unsigned SW      = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SW-1:0]    wstrb,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] entry_val [DEPTH];
    logic             wr_eff;
    logic             byp_ok;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;

    // A write is effective only if it can actually change a storage entry.
    always_comb begin
        wr_eff = we && (|wstrb) && (32'(waddr) < DEPTH)
                 && !((ZERO_REG != 0) && (waddr == '0));
        byp_ok = (BYPASS != 0) && wr_eff && !reset;
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign entry_val[i] = '0;
        end else begin : g_store
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clock (clock),
                .reset (reset),
                .en    (wr_eff && (waddr == AW'(i))),
                .strb  (wstrb),
                .d     (wdata),
                .q     (entry_val[i])
            );
        end
    end

    always_comb begin
        wr_old = '0;
        if (32'(waddr) < DEPTH) begin
            wr_old = entry_val[waddr];
        end
        wr_merged = WIDTH'(merge(MAX_W'(wr_old), MAX_W'(wdata), MAX_S'(wstrb)));
    end

    // Read muxes: out-of-range reads return zero; bypass wins over storage.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (32'(raddr_a) < DEPTH) begin
            rdata_a = entry_val[raddr_a];
        end
        if (32'(raddr_b) < DEPTH) begin
            rdata_b = entry_val[raddr_b];
        end
        if (byp_ok && (raddr_a == waddr)) begin
            rdata_a = wr_merged;
        end
        if (byp_ok && (raddr_b == waddr)) begin
            rdata_b = wr_merged;
        end
    end

endmodule
